// File: rtl/pe_writeback.sv
// Writeback stage behind the butterfly PE: tracks issued butterflies through the PE
// latency, buffers the results with their addresses, and drains them to coefficient memory.
module pe_writeback #(
  parameter int unsigned data_width = 14,
  parameter int unsigned addr_width = 8,
  parameter int unsigned pe_latency = 6,
  parameter int unsigned fifo_depth = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  input  logic [addr_width-1:0] in_addr_u,
  input  logic [addr_width-1:0] in_addr_v,
  input  logic [data_width-1:0] bf_lower,
  input  logic [data_width-1:0] bf_upper,
  input  logic                  wr_ready,
  output logic                  wr_en,
  output logic [addr_width-1:0] wr_addr_a,
  output logic [data_width-1:0] wr_data_a,
  output logic [addr_width-1:0] wr_addr_b,
  output logic [data_width-1:0] wr_data_b,
  output logic                  issue_stall,
  output logic                  idle,
  output logic                  overflow
);

  // Stage 0 is the live issue; registered stages 1..pe_latency-1 follow it, so the
  // tap lines up with the PE result in the cycle it is pushed.
  localparam int unsigned n_stages = pe_latency - 1;
  localparam int unsigned ptr_w    = $clog2(fifo_depth);
  localparam int unsigned cnt_w    = $clog2(fifo_depth + 1);
  localparam int unsigned infl_w   = $clog2(pe_latency);
  localparam int unsigned sum_w    = $clog2(fifo_depth + pe_latency) + 1;

  typedef struct packed {
    logic [addr_width-1:0] addr_u;
    logic [data_width-1:0] data_u;
    logic [addr_width-1:0] addr_v;
    logic [data_width-1:0] data_v;
  } wb_entry_t;

  logic [n_stages-1:0]   dl_valid;
  logic [addr_width-1:0] dl_addr_u [n_stages];
  logic [addr_width-1:0] dl_addr_v [n_stages];

  wb_entry_t             fifo_mem [fifo_depth];
  logic [ptr_w-1:0]      wr_ptr;
  logic [ptr_w-1:0]      rd_ptr;
  logic [cnt_w-1:0]      count;
  logic [infl_w-1:0]     inflight;

  logic      tap_valid;
  logic      empty;
  logic      full;
  logic      push;
  logic      pop;
  logic      drop;
  wb_entry_t tap_entry;
  wb_entry_t head;

  // Address delay line; addresses only load on a real issue
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      dl_valid <= '0;
      for (int unsigned i = 0; i < n_stages; i++) begin
        dl_addr_u[i] <= '0;
        dl_addr_v[i] <= '0;
      end
    end else begin
      dl_valid[0] <= in_valid;
      if (in_valid) begin
        dl_addr_u[0] <= in_addr_u;
        dl_addr_v[0] <= in_addr_v;
      end
      for (int unsigned i = 1; i < n_stages; i++) begin
        dl_valid[i]  <= dl_valid[i-1];
        dl_addr_u[i] <= dl_addr_u[i-1];
        dl_addr_v[i] <= dl_addr_v[i-1];
      end
    end
  end

  always_comb begin
    tap_valid        = dl_valid[n_stages-1];
    tap_entry.addr_u = dl_addr_u[n_stages-1];
    tap_entry.data_u = bf_lower;
    tap_entry.addr_v = dl_addr_v[n_stages-1];
    tap_entry.data_v = bf_upper;
  end

  always_comb begin
    inflight = '0;
    for (int unsigned i = 0; i < n_stages; i++) begin
      inflight = inflight + infl_w'(dl_valid[i]);
    end
  end

  // A full FIFO still accepts a push when the head leaves in the same cycle
  always_comb begin
    empty = (count == '0);
    full  = (count == cnt_w'(fifo_depth));
    pop   = !empty && wr_ready;
    push  = tap_valid && (!full || pop);
    drop  = tap_valid && full && !pop;
  end

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_mem[wr_ptr] <= tap_entry;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + ptr_w'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + ptr_w'(1);
      end
      if (push && !pop) begin
        count <= count + cnt_w'(1);
      end else if (pop && !push) begin
        count <= count - cnt_w'(1);
      end
      if (drop) begin
        overflow <= 1'b1;
      end
    end
  end

  // Show-ahead head; fields read zero whenever nothing is buffered
  always_comb begin
    head      = fifo_mem[rd_ptr];
    wr_en     = !empty;
    wr_addr_a = empty ? '0 : head.addr_u;
    wr_data_a = empty ? '0 : head.data_u;
    wr_addr_b = empty ? '0 : head.addr_v;
    wr_data_b = empty ? '0 : head.data_v;
  end

  always_comb begin
    issue_stall = (sum_w'(count) + sum_w'(inflight)) >= sum_w'(fifo_depth - 1);
    idle        = (inflight == '0) && empty;
  end

endmodule

// File: tb/tb_pe_writeback.sv
// Directed-plus-random bench for pe_writeback against a queue-based model of the
// PE pipeline and the writeback buffer.
module tb_pe_writeback;

  localparam int unsigned DW    = 14;
  localparam int unsigned AW    = 8;
  localparam int unsigned LAT   = 6;
  localparam int unsigned DEPTH = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic [AW-1:0] in_addr_u;
  logic [AW-1:0] in_addr_v;
  logic [DW-1:0] bf_lower;
  logic [DW-1:0] bf_upper;
  logic          wr_ready;
  logic          wr_en;
  logic [AW-1:0] wr_addr_a;
  logic [DW-1:0] wr_data_a;
  logic [AW-1:0] wr_addr_b;
  logic [DW-1:0] wr_data_b;
  logic          issue_stall;
  logic          idle;
  logic          overflow;

  pe_writeback #(
    .data_width(DW), .addr_width(AW), .pe_latency(LAT), .fifo_depth(DEPTH)
  ) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_addr_u(in_addr_u),
    .in_addr_v(in_addr_v), .bf_lower(bf_lower), .bf_upper(bf_upper),
    .wr_ready(wr_ready), .wr_en(wr_en), .wr_addr_a(wr_addr_a),
    .wr_data_a(wr_data_a), .wr_addr_b(wr_addr_b), .wr_data_b(wr_data_b),
    .issue_stall(issue_stall), .idle(idle), .overflow(overflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    int            due;
    logic [AW-1:0] au;
    logic [AW-1:0] av;
    logic [DW-1:0] lo;
    logic [DW-1:0] up;
  } pe_t;

  typedef struct {
    logic [AW-1:0] au;
    logic [DW-1:0] lo;
    logic [AW-1:0] av;
    logic [DW-1:0] up;
  } wb_t;

  pe_t pq[$];
  wb_t mq[$];
  bit  m_ovf;
  int  cyc;
  int  checks;
  int  errors;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  function automatic bit m_stall();
    return (mq.size() + pq.size()) >= int'(DEPTH - 1);
  endfunction

  task automatic check_outputs();
    bit e_en;
    e_en = (mq.size() != 0);
    chk("wr_en", 32'(wr_en), 32'(e_en));
    if (e_en) begin
      chk("wr_addr_a", 32'(wr_addr_a), 32'(mq[0].au));
      chk("wr_data_a", 32'(wr_data_a), 32'(mq[0].lo));
      chk("wr_addr_b", 32'(wr_addr_b), 32'(mq[0].av));
      chk("wr_data_b", 32'(wr_data_b), 32'(mq[0].up));
    end
    chk("issue_stall", 32'(issue_stall), 32'(m_stall()));
    chk("idle", 32'(idle), 32'((mq.size() == 0) && (pq.size() == 0)));
    chk("overflow", 32'(overflow), 32'(m_ovf));
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_wr_en"}, 32'(wr_en), 32'd0);
    chk({tag, "_issue_stall"}, 32'(issue_stall), 32'd0);
    chk({tag, "_idle"}, 32'(idle), 32'd1);
    chk({tag, "_overflow"}, 32'(overflow), 32'd0);
    chk({tag, "_wr_addr_a"}, 32'(wr_addr_a), 32'd0);
    chk({tag, "_wr_data_a"}, 32'(wr_data_a), 32'd0);
    chk({tag, "_wr_addr_b"}, 32'(wr_addr_b), 32'd0);
    chk({tag, "_wr_data_b"}, 32'(wr_data_b), 32'd0);
  endtask

  // One clock cycle: drive, check state-derived outputs, then advance the model
  task automatic cycle(input bit vld, input logic [AW-1:0] au, input logic [AW-1:0] av,
                       input logic [DW-1:0] lo, input logic [DW-1:0] up, input bit rdy);
    pe_t e;
    bit  tapv;
    @(negedge clk);
    cyc++;
    in_valid  = vld;
    in_addr_u = au;
    in_addr_v = av;
    wr_ready  = rdy;
    tapv      = (pq.size() != 0) && (pq[0].due == cyc);
    if (tapv) begin
      bf_lower = pq[0].lo;
      bf_upper = pq[0].up;
    end else begin
      bf_lower = DW'($urandom);
      bf_upper = DW'($urandom);
    end
    check_outputs();
    if ((mq.size() != 0) && rdy) void'(mq.pop_front());
    if (tapv) begin
      e = pq.pop_front();
      if (mq.size() < int'(DEPTH)) mq.push_back('{au: e.au, lo: e.lo, av: e.av, up: e.up});
      else m_ovf = 1'b1;
    end
    if (vld) pq.push_back('{due: cyc + int'(LAT) - 1, au: au, av: av, lo: lo, up: up});
  endtask

  task automatic rnd_cycle(input bit vld, input bit rdy);
    cycle(vld, AW'($urandom), AW'($urandom), DW'($urandom), DW'($urandom), rdy);
  endtask

  task automatic clear_model();
    pq.delete();
    mq.delete();
    m_ovf = 1'b0;
  endtask

  initial begin
    int t0;
    checks = 0;
    errors = 0;
    cyc    = 0;
    m_ovf  = 1'b0;
    rst = 1'b0; in_valid = 1'b0; in_addr_u = '0; in_addr_v = '0;
    bf_lower = '0; bf_upper = '0; wr_ready = 1'b0;
    repeat (2) @(negedge clk);
    check_reset_outputs("reset");
    rst = 1'b1;

    // Single butterfly
    cycle(1'b1, 8'd3, 8'd131, 14'd100, 14'd12000, 1'b1);
    repeat (10) rnd_cycle(1'b0, 1'b1);

    // Streaming 32 back-to-back
    repeat (32) rnd_cycle(1'b1, 1'b1);
    repeat (10) rnd_cycle(1'b0, 1'b1);

    // Backpressure, upstream honours issue_stall
    repeat (24) rnd_cycle(!m_stall(), 1'b0);
    chk("bp_fill_level", 32'(mq.size()), 32'(DEPTH - 1));
    repeat (12) rnd_cycle(1'b0, 1'b1);

    // Forced overflow: 10 issues ignoring the stall
    repeat (10) rnd_cycle(1'b1, 1'b0);
    repeat (10) rnd_cycle(1'b0, 1'b0);
    repeat (12) rnd_cycle(1'b0, 1'b1);
    @(negedge clk);
    rst = 1'b0;
    #1;
    clear_model();
    check_reset_outputs("ovf_clear");
    @(negedge clk);
    rst = 1'b1;

    // Full FIFO with a simultaneous push and pop
    t0 = cyc + 1;
    repeat (9) rnd_cycle(1'b1, 1'b0);
    while (cyc < t0 + 14) rnd_cycle(1'b0, cyc + 1 == t0 + 13);
    repeat (12) rnd_cycle(1'b0, 1'b1);

    // Random traffic
    repeat (300) rnd_cycle(($urandom_range(0, 2) != 0) && !m_stall(), $urandom_range(0, 3) != 0);
    repeat (12) rnd_cycle(1'b0, 1'b1);

    // Async reset with 3 in flight and 4 buffered
    repeat (4) rnd_cycle(1'b1, 1'b0);
    repeat (3) rnd_cycle(1'b0, 1'b0);
    repeat (3) rnd_cycle(1'b1, 1'b0);
    chk("pre_reset_buffered", 32'(mq.size()), 32'd4);
    chk("pre_reset_inflight", 32'(pq.size()), 32'd3);
    @(negedge clk);
    in_valid = 1'b0;
    #2;
    chk("pre_reset_wr_en", 32'(wr_en), 32'd1);
    rst = 1'b0;
    #1;
    check_reset_outputs("async_reset");
    clear_model();
    @(negedge clk);
    rst = 1'b1;
    repeat (15) rnd_cycle(1'b0, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/pe_writeback.md
Name: pe_writeback

Overview:
- Downstream stage of the butterfly PE. Tracks each issued butterfly through the PE's fixed pipeline latency.
- Captures bf_lower/bf_upper when they emerge, pairs them with their coefficient addresses, and buffers them in a small FIFO.
- Drains the FIFO to the coefficient-memory write port under ready backpressure.
- Provides an issue-stall signal so the upstream address generator never overruns the buffer.

Parameters:
- data_width, 14, coefficient width; matches PE data path.
- addr_width, 8, coefficient memory address width.
- pe_latency, 6, cycles from u/v presented at PE input to valid bf_upper/bf_lower. Identical for sel_ntt=0 and sel_ntt=1.
- fifo_depth, 8, writeback FIFO entries; power of two, >=2.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous active-low reset (0 = reset).
- in_valid  in  1  a butterfly's u/v is presented to the PE this cycle.
- in_addr_u  in  addr_width  destination address of the u-side result.
- in_addr_v  in  addr_width  destination address of the v-side result.
- bf_lower  in  data_width  PE lower output; written to addr_u.
- bf_upper  in  data_width  PE upper output; written to addr_v.
- wr_ready  in  1  memory accepts a write this cycle.
- wr_en  out  1  write request valid.
- wr_addr_a  out  addr_width  address for wr_data_a.
- wr_data_a  out  data_width  bf_lower result.
- wr_addr_b  out  addr_width  address for wr_data_b.
- wr_data_b  out  data_width  bf_upper result.
- issue_stall  out  1  upstream must not assert in_valid next cycle.
- idle  out  1  no butterflies in flight and FIFO empty.
- overflow  out  1  sticky error: a result was dropped.

Behaviour:
- Reset (rst=0, asynchronous): delay line valid bits, FIFO pointers/count and overflow clear. Outputs: wr_en=0, issue_stall=0, idle=1, overflow=0. All address/data outputs read 0.
- Reset mid-operation discards all in-flight and buffered results; no write is issued afterwards.

Delay line:
- Shift register, pe_latency stages, each stage holding {valid, addr_u, addr_v}.
- Stage 0 loads {in_valid, in_addr_u, in_addr_v} every cycle.
- Addresses are not captured when in_valid=0; stage valid=0.
- Tap at stage pe_latency-1 (emerging entry) aligns with bf_lower/bf_upper for that butterfly.

Push:
- When the tap valid=1, push {addr_u, bf_lower, addr_v, bf_upper} into the FIFO in that same cycle.

FIFO:
- Show-ahead. wr_en = !empty. wr_* fields show the head entry.
- Pop when wr_en && wr_ready. Holding wr_ready=0 keeps the head and its outputs stable.
- Simultaneous push and pop: legal at any fill level, including full; count unchanged.
- Push when full and no pop: entry dropped, overflow set to 1 and held until reset, FIFO contents unchanged.
- Pointers wrap modulo fifo_depth.

Control outputs:
- inflight = number of valid delay-line stages.
- issue_stall = (count + inflight) >= fifo_depth - 1. Registered-state-derived combinational, no input-to-output path. This guarantees no overflow when upstream obeys it.
- idle = (inflight == 0) && empty.
- Mode (sel_ntt) changes are upstream's responsibility. Latency is identical in both modes, so no drain is required.

Latency:
- in_valid at cycle T -> entry pushed at edge ending cycle T+pe_latency-1.
- wr_en high from cycle T+pe_latency when the FIFO was empty.

Test Plan:
- Single butterfly: in_valid at T0, addr_u=3, addr_v=131, bf_lower=100, bf_upper=12000 at the tap, wr_ready=1 -> wr_en exactly one cycle at T0+6 with a=(3,100), b=(131,12000); idle returns 1 the next cycle.
- Streaming 32 butterflies back-to-back, wr_ready=1 -> 32 writes in consecutive cycles, in order, addresses intact, issue_stall never 1, overflow=0.
- Backpressure: wr_ready=0 throughout, upstream honours issue_stall -> issue_stall rises when count+inflight reaches 7; FIFO holds 7 entries; overflow stays 0; releasing wr_ready drains all 7 in order.
- Forced overflow: ignore issue_stall with wr_ready=0 and issue 10 butterflies -> overflow=1 after the 9th push attempt, the 8 earliest entries are retained, and overflow persists until rst=0.
- Full with simultaneous push/pop: FIFO full, wr_ready=1, tap valid -> head popped, new entry appended, count stays 8, overflow=0.
- Async reset mid-stream: assert rst=0 between edges with 3 in flight and 4 buffered -> wr_en, issue_stall and overflow go 0 and idle goes 1 immediately; no writes after release.
